// File: rtl/arbitro_buzzer_pkg.sv
// rtl/arbitro_buzzer_pkg.sv - shared state codes and note constants for the buzzer arbiter
package arbitro_buzzer_pkg;

    localparam int NOTE_W = 4;

    // Note code that means "rest": the link is held but nothing sounds.
    localparam logic [NOTE_W-1:0] NOTA_SILENCIO = '0;

    // Codes are visible on db_estado, so they are fixed explicitly.
    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        TOCA_SEQ  = 3'd1,
        PAUSA_SEQ = 3'd2,
        TOCA_BTN  = 3'd3,
        PAUSA_BTN = 3'd4
    } estado_t;

    // True in the states where the latched note is driven to the Arduino.
    function automatic logic estado_toca(input estado_t e);
        return (e == TOCA_SEQ) || (e == TOCA_BTN);
    endfunction

endpackage

// File: rtl/arbitro_buzzer_contador.sv
// rtl/arbitro_buzzer_contador.sv - saturating up-counter shared by hold and gap timing
module contador_tempo #(
    parameter int CNT_W = 25
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zera,
    input  logic             conta,
    output logic [CNT_W-1:0] valor
);

    localparam logic [CNT_W-1:0] VALOR_MAX = '1;

    // Clear has priority; counting stops at the top value instead of wrapping,
    // so a very long button hold still reads as "past the minimum".
    always_ff @(posedge clock) begin
        if (!reset) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta && (valor != VALOR_MAX)) begin
            valor <= valor + CNT_W'(1);
        end
    end

endmodule

// File: rtl/arbitro_buzzer.sv
// rtl/arbitro_buzzer.sv - arbitrates the Arduino buzzer link between sequence playback and button echo
module arbitro_buzzer #(
    parameter int NOTE_W   = arbitro_buzzer_pkg::NOTE_W,
    parameter int CNT_W    = 25,
    parameter int HOLD_SEQ = 25000000,
    parameter int GAP_SEQ  = 5000000,
    parameter int MIN_BTN  = 5000000,
    parameter int GAP_BTN  = 2500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_seq,
    input  logic [NOTE_W-1:0] nota_seq,
    input  logic              req_btn,
    input  logic [NOTE_W-1:0] nota_btn,
    input  logic              silencia,
    input  logic              ativo,
    output logic [NOTE_W-1:0] arduino_nota,
    output logic              arduino_valido,
    output logic              muda_nota,
    output logic              grant_seq,
    output logic              grant_btn,
    output logic              ocupado,
    output logic [2:0]        db_estado
);

    import arbitro_buzzer_pkg::*;

    // The counter starts at 0 on the first cycle of a state, so a state that
    // must last N cycles is left when the counter reads N-1.
    localparam logic [CNT_W-1:0] FIM_HOLD_SEQ = CNT_W'(HOLD_SEQ - 1);
    localparam logic [CNT_W-1:0] FIM_GAP_SEQ  = CNT_W'(GAP_SEQ - 1);
    localparam logic [CNT_W-1:0] FIM_MIN_BTN  = CNT_W'(MIN_BTN - 1);
    localparam logic [CNT_W-1:0] FIM_GAP_BTN  = CNT_W'(GAP_BTN - 1);

    estado_t           estado;
    estado_t           estado_prox;
    logic [NOTE_W-1:0] nota_reg;
    logic [NOTE_W-1:0] nota_prox;
    logic              muda_reg;
    logic              muda_prox;
    logic [CNT_W-1:0]  contagem;
    logic              zera;
    logic              conta;

    contador_tempo #(
        .CNT_W (CNT_W)
    ) u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta),
        .valor (contagem)
    );

    // State, latched note and the end-of-note pulse are all registered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado   <= OCIOSO;
            nota_reg <= '0;
            muda_reg <= 1'b0;
        end else begin
            estado   <= estado_prox;
            nota_reg <= nota_prox;
            muda_reg <= muda_prox;
        end
    end

    // Next state: abort wins over everything, sequence wins over button, and a
    // granted sequence note runs its full hold and gap regardless of req_seq.
    always_comb begin
        estado_prox = estado;
        nota_prox   = nota_reg;
        muda_prox   = 1'b0;
        if (silencia || !ativo) begin
            estado_prox = OCIOSO;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (req_seq) begin
                        estado_prox = TOCA_SEQ;
                        nota_prox   = nota_seq;
                    end else if (req_btn) begin
                        estado_prox = TOCA_BTN;
                        nota_prox   = nota_btn;
                    end
                end
                TOCA_SEQ: begin
                    if (contagem >= FIM_HOLD_SEQ) begin
                        estado_prox = PAUSA_SEQ;
                    end
                end
                PAUSA_SEQ: begin
                    if (contagem >= FIM_GAP_SEQ) begin
                        estado_prox = OCIOSO;
                        muda_prox   = 1'b1;
                    end
                end
                TOCA_BTN: begin
                    if (req_seq) begin
                        estado_prox = PAUSA_BTN;
                    end else if (!req_btn && (contagem >= FIM_MIN_BTN)) begin
                        estado_prox = PAUSA_BTN;
                    end
                end
                PAUSA_BTN: begin
                    if (contagem >= FIM_GAP_BTN) begin
                        estado_prox = OCIOSO;
                    end
                end
                default: begin
                    estado_prox = OCIOSO;
                end
            endcase
        end
    end

    // Counter restarts on every state change and is held at zero while idle.
    always_comb begin
        zera  = (estado_prox != estado) || (estado == OCIOSO);
        conta = !zera;
    end

    assign arduino_nota   = estado_toca(estado) ? nota_reg : NOTE_W'(NOTA_SILENCIO);
    assign arduino_valido = estado_toca(estado) && (nota_reg != NOTE_W'(NOTA_SILENCIO));
    assign muda_nota      = muda_reg;
    assign grant_seq      = (estado == TOCA_SEQ) || (estado == PAUSA_SEQ);
    assign grant_btn      = (estado == TOCA_BTN) || (estado == PAUSA_BTN);
    assign ocupado        = (estado != OCIOSO);
    assign db_estado      = estado;

endmodule

// File: tb/tb_arbitro_buzzer.sv
// tb/tb_arbitro_buzzer.sv - self-checking bench for arbitro_buzzer
module tb_arbitro_buzzer;

    localparam int HOLD_SEQ = 4;
    localparam int GAP_SEQ  = 2;
    localparam int MIN_BTN  = 3;
    localparam int GAP_BTN  = 2;

    logic       clock;
    logic       reset;
    logic       req_seq;
    logic [3:0] nota_seq;
    logic       req_btn;
    logic [3:0] nota_btn;
    logic       silencia;
    logic       ativo;
    logic [3:0] arduino_nota;
    logic       arduino_valido;
    logic       muda_nota;
    logic       grant_seq;
    logic       grant_btn;
    logic       ocupado;
    logic [2:0] db_estado;

    int checks = 0;
    int errors = 0;

    arbitro_buzzer #(
        .NOTE_W   (4),
        .CNT_W    (3),
        .HOLD_SEQ (HOLD_SEQ),
        .GAP_SEQ  (GAP_SEQ),
        .MIN_BTN  (MIN_BTN),
        .GAP_BTN  (GAP_BTN)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_seq        (req_seq),
        .nota_seq       (nota_seq),
        .req_btn        (req_btn),
        .nota_btn       (nota_btn),
        .silencia       (silencia),
        .ativo          (ativo),
        .arduino_nota   (arduino_nota),
        .arduino_valido (arduino_valido),
        .muda_nota      (muda_nota),
        .grant_seq      (grant_seq),
        .grant_btn      (grant_btn),
        .ocupado        (ocupado),
        .db_estado      (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int rs, ns, rb, nb, sil, at, rst;
        int est, nota, val, muda;
    } vec_t;

    vec_t tab[$];

    // Reference model: what the link is doing and how many cycles are left
    // (sequence/gaps) or have elapsed (button sound).
    typedef enum {LIVRE, SEQ_SOM, SEQ_PAUSA, BTN_SOM, BTN_PAUSA} fase_t;
    fase_t m_fase = LIVRE;
    int    m_cnt  = 0;
    int    m_nota = 0;
    int    m_muda = 0;

    function automatic vec_t mk(int rs, int ns, int rb, int nb, int sil, int at, int rst,
                                int est, int nota, int val, int muda);
        vec_t v;
        v.rs = rs; v.ns = ns; v.rb = rb; v.nb = nb; v.sil = sil; v.at = at; v.rst = rst;
        v.est = est; v.nota = nota; v.val = val; v.muda = muda;
        return v;
    endfunction

    task automatic chk(input string nome, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", nome, got, exp, $time);
        end
    endtask

    task automatic aplica(input vec_t v);
        reset    = 1'(v.rst);
        req_seq  = 1'(v.rs);
        nota_seq = 4'(v.ns);
        req_btn  = 1'(v.rb);
        nota_btn = 4'(v.nb);
        silencia = 1'(v.sil);
        ativo    = 1'(v.at);
    endtask

    task automatic modelo_passo();
        int muda_n;
        muda_n = 0;
        if (!reset) begin
            m_fase = LIVRE;
            m_nota = 0;
        end else if (silencia || !ativo) begin
            m_fase = LIVRE;
        end else begin
            case (m_fase)
                LIVRE: begin
                    if (req_seq) begin
                        m_fase = SEQ_SOM; m_cnt = HOLD_SEQ; m_nota = int'(nota_seq);
                    end else if (req_btn) begin
                        m_fase = BTN_SOM; m_cnt = 1; m_nota = int'(nota_btn);
                    end
                end
                SEQ_SOM: begin
                    if (m_cnt == 1) begin m_fase = SEQ_PAUSA; m_cnt = GAP_SEQ; end
                    else m_cnt = m_cnt - 1;
                end
                SEQ_PAUSA: begin
                    if (m_cnt == 1) begin m_fase = LIVRE; muda_n = 1; end
                    else m_cnt = m_cnt - 1;
                end
                BTN_SOM: begin
                    if (req_seq || (!req_btn && m_cnt >= MIN_BTN)) begin
                        m_fase = BTN_PAUSA; m_cnt = GAP_BTN;
                    end else m_cnt = m_cnt + 1;
                end
                BTN_PAUSA: begin
                    if (m_cnt == 1) m_fase = LIVRE;
                    else m_cnt = m_cnt - 1;
                end
                default: m_fase = LIVRE;
            endcase
        end
        m_muda = muda_n;
    endtask

    task automatic confere_modelo();
        int som, est;
        som = (m_fase == SEQ_SOM || m_fase == BTN_SOM) ? 1 : 0;
        case (m_fase)
            SEQ_SOM:   est = 1;
            SEQ_PAUSA: est = 2;
            BTN_SOM:   est = 3;
            BTN_PAUSA: est = 4;
            default:   est = 0;
        endcase
        chk("model db_estado", int'(db_estado), est);
        chk("model arduino_nota", int'(arduino_nota), som ? m_nota : 0);
        chk("model arduino_valido", int'(arduino_valido), (som && m_nota != 0) ? 1 : 0);
        chk("model muda_nota", int'(muda_nota), m_muda);
        chk("model grant_seq", int'(grant_seq), (est == 1 || est == 2) ? 1 : 0);
        chk("model grant_btn", int'(grant_btn), (est == 3 || est == 4) ? 1 : 0);
        chk("model ocupado", int'(ocupado), (est != 0) ? 1 : 0);
    endtask

    task automatic ciclo();
        @(posedge clock);
        modelo_passo();
        @(negedge clock);
        confere_modelo();
    endtask

    initial begin
        // Sequence note with input change mid-note (latched value kept)
        tab.push_back(mk(1,5,0,0,0,1,1, 1,5,1,0));
        tab.push_back(mk(0,8,0,0,0,1,1, 1,5,1,0));
        tab.push_back(mk(0,8,0,0,0,1,1, 1,5,1,0));
        tab.push_back(mk(0,8,0,0,0,1,1, 1,5,1,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 2,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 2,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,1));
        tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0));
        // Contention: sequence wins, button only after muda_nota
        tab.push_back(mk(1,2,1,9,0,1,1, 1,2,1,0));
        tab.push_back(mk(0,2,1,9,0,1,1, 1,2,1,0));
        tab.push_back(mk(0,2,1,9,0,1,1, 1,2,1,0));
        tab.push_back(mk(0,2,1,9,0,1,1, 1,2,1,0));
        tab.push_back(mk(0,2,1,9,0,1,1, 2,0,0,0));
        tab.push_back(mk(0,2,1,9,0,1,1, 2,0,0,0));
        tab.push_back(mk(0,2,1,9,0,1,1, 0,0,0,1));
        tab.push_back(mk(0,2,1,9,0,1,1, 3,9,1,0));
        tab.push_back(mk(0,0,0,9,0,1,1, 3,9,1,0));
        tab.push_back(mk(0,0,0,9,0,1,1, 3,9,1,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 4,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 4,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0));
        // Button pulse: MIN_BTN sound, GAP_BTN silence, no muda_nota
        tab.push_back(mk(0,0,1,3,0,1,1, 3,3,1,0));
        tab.push_back(mk(0,0,0,3,0,1,1, 3,3,1,0));
        tab.push_back(mk(0,0,0,3,0,1,1, 3,3,1,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 4,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 4,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0));
        // Preemption of a held button, then the sequence note, then silencia
        tab.push_back(mk(0,0,1,7,0,1,1, 3,7,1,0));
        tab.push_back(mk(0,0,1,7,0,1,1, 3,7,1,0));
        tab.push_back(mk(1,6,1,7,0,1,1, 4,0,0,0));
        tab.push_back(mk(1,6,1,7,0,1,1, 4,0,0,0));
        tab.push_back(mk(1,6,1,7,0,1,1, 0,0,0,0));
        tab.push_back(mk(1,6,0,0,0,1,1, 1,6,1,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 1,6,1,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 1,6,1,0));
        tab.push_back(mk(0,0,0,0,1,1,1, 0,0,0,0));
        for (int i = 0; i < 6; i++) tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0));
        // ativo=0 mid-note and as a request blocker
        tab.push_back(mk(1,4,0,0,0,1,1, 1,4,1,0));
        tab.push_back(mk(0,4,0,0,0,1,1, 1,4,1,0));
        tab.push_back(mk(0,4,0,0,0,0,1, 0,0,0,0));
        tab.push_back(mk(1,4,1,4,0,0,1, 0,0,0,0));
        for (int i = 0; i < 5; i++) tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0));
        // Reset mid-note
        tab.push_back(mk(1,4,0,0,0,1,1, 1,4,1,0));
        tab.push_back(mk(1,4,0,0,0,1,0, 0,0,0,0));
        for (int i = 0; i < 5; i++) tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0));
        // silencia overrides requests in OCIOSO; silencia during the gap drops muda_nota
        tab.push_back(mk(1,3,1,3,1,1,1, 0,0,0,0));
        tab.push_back(mk(1,3,0,0,0,1,1, 1,3,1,0));
        tab.push_back(mk(0,3,0,0,0,1,1, 1,3,1,0));
        tab.push_back(mk(0,3,0,0,0,1,1, 1,3,1,0));
        tab.push_back(mk(0,3,0,0,0,1,1, 1,3,1,0));
        tab.push_back(mk(0,3,0,0,0,1,1, 2,0,0,0));
        tab.push_back(mk(0,3,0,0,1,1,1, 0,0,0,0));
        tab.push_back(mk(0,3,0,0,0,1,1, 0,0,0,0));
        // Rest note: timed normally, never valid, still muda_nota
        tab.push_back(mk(1,0,0,0,0,1,1, 1,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 1,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 1,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 1,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 2,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 2,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,1));
        tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0));
        // Long button hold past counter saturation (3-bit counter): release exits at once
        tab.push_back(mk(0,0,1,2,0,1,1, 3,2,1,0));
        for (int i = 0; i < 8; i++) tab.push_back(mk(0,0,1,2,0,1,1, 3,2,1,0));
        tab.push_back(mk(0,0,0,2,0,1,1, 4,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 4,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0));
        // Held req_seq replays only after one OCIOSO cycle carrying muda_nota
        tab.push_back(mk(1,1,0,0,0,1,1, 1,1,1,0));
        for (int i = 0; i < 3; i++) tab.push_back(mk(1,1,0,0,0,1,1, 1,1,1,0));
        tab.push_back(mk(1,1,0,0,0,1,1, 2,0,0,0));
        tab.push_back(mk(1,1,0,0,0,1,1, 2,0,0,0));
        tab.push_back(mk(1,1,0,0,0,1,1, 0,0,0,1));
        tab.push_back(mk(1,1,0,0,0,1,1, 1,1,1,0));
        for (int i = 0; i < 3; i++) tab.push_back(mk(0,0,0,0,0,1,1, 1,1,1,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 2,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 2,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,1));
        tab.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0));

        // Reset state
        aplica(mk(1,5,1,5,0,1,0, 0,0,0,0));
        @(posedge clock);
        modelo_passo();
        @(posedge clock);
        modelo_passo();
        @(negedge clock);
        chk("reset db_estado", int'(db_estado), 0);
        chk("reset arduino_nota", int'(arduino_nota), 0);
        chk("reset arduino_valido", int'(arduino_valido), 0);
        chk("reset muda_nota", int'(muda_nota), 0);
        chk("reset grant_seq", int'(grant_seq), 0);
        chk("reset grant_btn", int'(grant_btn), 0);
        chk("reset ocupado", int'(ocupado), 0);
        aplica(mk(0,0,0,0,0,1,1, 0,0,0,0));
        ciclo();

        // Directed vectors
        for (int i = 0; i < tab.size(); i++) begin
            aplica(tab[i]);
            ciclo();
            chk($sformatf("vec%0d db_estado", i), int'(db_estado), tab[i].est);
            chk($sformatf("vec%0d arduino_nota", i), int'(arduino_nota), tab[i].nota);
            chk($sformatf("vec%0d arduino_valido", i), int'(arduino_valido), tab[i].val);
            chk($sformatf("vec%0d muda_nota", i), int'(muda_nota), tab[i].muda);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 199) != 0);
            silencia = ($urandom_range(0, 39) == 0);
            ativo    = ($urandom_range(0, 29) != 0);
            req_seq  = ($urandom_range(0, 5) == 0);
            req_btn  = ($urandom_range(0, 2) == 0);
            nota_seq = 4'($urandom_range(0, 15));
            nota_btn = 4'($urandom_range(0, 15));
            ciclo();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_buzzer.md
Name: arbitro_buzzer

Overview:
Shares the Arduino buzzer link between two requesters: sequence playback (the note being shown) and button echo (the note the player is pressing). Sequences each note as a timed hold followed by a silent gap. Returns a one-cycle muda_nota pulse to the game control unit when a sequence note is complete. Sits between the game control unit / note memory and the Arduino output pins.

Parameters:
NOTE_W, 4, width of note code; code 0 = rest (silence)
CNT_W, 25, width of the shared hold/gap counter
HOLD_SEQ, 25000000, cycles a sequence note is sounded (0.5 s at 50 MHz)
GAP_SEQ, 5000000, silent cycles after a sequence note
MIN_BTN, 5000000, minimum cycles a button echo is sounded
GAP_BTN, 2500000, silent cycles after a button echo

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset, sampled on rising edge of clock
req_seq  in  1  level; sequence note requested
nota_seq  in  NOTE_W  sequence note code
req_btn  in  1  level; a button is held
nota_btn  in  NOTE_W  button note code
silencia  in  1  abort the current note and force idle
ativo  in  1  Arduino link enabled
arduino_nota  out  NOTE_W  note driven to the Arduino
arduino_valido  out  1  arduino_nota is meaningful
muda_nota  out  1  one-cycle pulse: sequence note plus gap finished
grant_seq  out  1  sequence owns the link
grant_btn  out  1  button echo owns the link
ocupado  out  1  state is not OCIOSO
db_estado  out  3  state code for debug

Behaviour:
- Reset (reset=0 at a clock edge): state OCIOSO, counter 0, note register 0. All outputs 0.
- FSM states and codes: OCIOSO=0, TOCA_SEQ=1, PAUSA_SEQ=2, TOCA_BTN=3, PAUSA_BTN=4.
- OCIOSO:
  - req_seq=1 and ativo=1 → TOCA_SEQ. Latch nota_seq. Clear counter.
  - else req_btn=1 and ativo=1 → TOCA_BTN. Latch nota_btn. Clear counter.
  - Simultaneous requests: sequence wins.
- TOCA_SEQ:
  - Lasts exactly HOLD_SEQ cycles, then → PAUSA_SEQ with counter cleared.
  - Dropping req_seq mid-note does not shorten the note; a granted note is committed.
- PAUSA_SEQ:
  - Lasts exactly GAP_SEQ cycles, then → OCIOSO.
  - muda_nota is registered and equals 1 only in the first OCIOSO cycle after PAUSA_SEQ.
  - Timing: req_seq sampled at edge k gives TOCA_SEQ for cycles k+1..k+HOLD_SEQ, PAUSA_SEQ for the next GAP_SEQ cycles, and muda_nota in cycle k+HOLD_SEQ+GAP_SEQ+1.
- TOCA_BTN:
  - Stays while req_btn=1 or counter < MIN_BTN−1, then → PAUSA_BTN.
  - Counter saturates at its maximum value; it never wraps.
  - req_seq=1 preempts: → PAUSA_BTN immediately, regardless of MIN_BTN.
- PAUSA_BTN: lasts GAP_BTN cycles, then → OCIOSO. No muda_nota.
- OCIOSO always lasts at least one cycle between notes, so a held req_seq replays only after muda_nota.
- Latched note: arduino_nota holds the latched value in TOCA_*; it is 0 elsewhere. Input note changes while a note is playing are ignored.
- arduino_valido = 1 in TOCA_* when latched note ≠ 0. A rest (code 0) still times HOLD_SEQ/GAP_SEQ and still produces muda_nota.
- Grants: grant_seq = 1 in TOCA_SEQ and PAUSA_SEQ; grant_btn = 1 in TOCA_BTN and PAUSA_BTN. The two are never both 1.
- silencia=1 or ativo=0 in any state → OCIOSO at the next edge, counter cleared, no muda_nota. silencia overrides new requests in OCIOSO.
- Reset mid-note: the next cycle shows reset values; any pending muda_nota is dropped.
- Counter: a single CNT_W-bit up-counter, cleared on every state entry. Each limit parameter must be < 2^CNT_W and ≥ 1.

Decomposition:
- Shared package: state encodings (OCIOSO..PAUSA_BTN), NOTE_W, NOTA_SILENCIO = 0.
- One sub-module, contador_tempo: CNT_W-bit counter with zera/conta inputs, saturating at its maximum value. It is reused for hold/gap timing.
- FSM and output registers stay in arbitro_buzzer.

Test Plan:
(Bench parameters: HOLD_SEQ=4, GAP_SEQ=2, MIN_BTN=3, GAP_BTN=2.)
1. Sequence note: req_seq=1, nota_seq=5 at edge 0. Required: arduino_nota=5 with arduino_valido=1 in cycles 1–4; silent in cycles 5–6; muda_nota=1 only in cycle 7.
2. Contention: req_seq=1 and req_btn=1 in the same OCIOSO cycle, nota_seq=2, nota_btn=9. Required: grant_seq=1, arduino_nota=2, grant_btn stays 0 until after muda_nota.
3. Button echo: req_btn pulsed for 1 cycle with nota_btn=3. Required: note 3 sounded for 3 cycles, then 2 silent cycles, then OCIOSO; muda_nota never asserted.
4. Preemption: req_btn held with nota_btn=7; req_seq=1 asserted in the 2nd TOCA_BTN cycle. Required: next cycle PAUSA_BTN (2 cycles), then OCIOSO, then TOCA_SEQ.
5. Abort: silencia=1 in the 3rd TOCA_SEQ cycle. Required: next cycle OCIOSO with all outputs 0 and no muda_nota; the same applies to ativo=0 and to reset=0 mid-note.
6. Rest: nota_seq=0 requested. Required: arduino_valido=0 throughout, and muda_nota still in cycle 7.
